// File: rtl/bios_watchdog_multi.sv
// BIOS boot watchdog: per-kick and whole-boot timeouts with image swap on expiry
// and power-off lockout once the retry budget is spent.
module bios_watchdog_multi #(
  parameter int         KICK_TICKS  = 32,
  parameter int         BOOT_TICKS  = 512,
  parameter int         MAX_RETRY   = 2,
  parameter int         RST_PULSE   = 16,
  parameter logic [7:0] CMD_KICK    = 8'hAA,
  parameter logic [7:0] CMD_SUSPEND = 8'h55,
  parameter logic [7:0] CMD_DISABLE = 8'h29,
  parameter logic [7:0] CMD_DONE    = 8'hFF
) (
  input  logic       LpcClock,
  input  logic       MainReset,
  input  logic       BootStart,
  input  logic       Tick,
  input  logic       CmdValid,
  input  logic [7:0] CmdData,
  output logic       BiosFinished,
  output logic       WdReset,
  output logic       ForceSwap,
  output logic       BiosSel,
  output logic       BiosPowerOff,
  output logic [3:0] RetryCnt,
  output logic [2:0] WdState,
  output logic [1:0] DPx
);

  localparam int KW = $clog2(KICK_TICKS + 1);
  localparam int BW = $clog2(BOOT_TICKS + 1);
  localparam int PW = $clog2(RST_PULSE + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] SUSPEND = 3'd2;
  localparam logic [2:0] NOBOOT  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] EXPIRED = 3'd5;
  localparam logic [2:0] LOCKOUT = 3'd6;

  logic [2:0]    state_r, state_s;
  logic [KW-1:0] kick_r, kick_s, kick_inc_s;
  logic [BW-1:0] boot_r, boot_s, boot_inc_s;
  logic [PW-1:0] pulse_r, pulse_s;
  logic [3:0]    retry_r, retry_s, retry_inc_s;
  logic          sel_r, sel_s, swap_r, swap_s, wd_r, wd_s, fin_r, fin_s;
  logic          off_r, off_s;
  logic [1:0]    dpx_r, dpx_s;
  logic          kick_cmd_s, susp_cmd_s, dis_cmd_s, done_cmd_s;

  assign kick_cmd_s  = CmdValid && (CmdData == CMD_KICK);
  assign susp_cmd_s  = CmdValid && (CmdData == CMD_SUSPEND);
  assign dis_cmd_s   = CmdValid && (CmdData == CMD_DISABLE);
  assign done_cmd_s  = CmdValid && (CmdData == CMD_DONE);
  // Counters saturate at their limit instead of wrapping.
  assign kick_inc_s  = (kick_r == KW'(KICK_TICKS)) ? kick_r : kick_r + KW'(1);
  assign boot_inc_s  = (boot_r == BW'(BOOT_TICKS)) ? boot_r : boot_r + BW'(1);
  assign retry_inc_s = (retry_r == 4'd15) ? retry_r : retry_r + 4'd1;

  // Next-state and next-output computation; every output is registered from these.
  always_comb begin
    state_s = state_r;
    kick_s  = kick_r;
    boot_s  = boot_r;
    pulse_s = pulse_r;
    retry_s = retry_r;
    sel_s   = sel_r;
    swap_s  = 1'b0;
    wd_s    = wd_r;
    fin_s   = fin_r;
    case (state_r)
      IDLE: begin
        if (BootStart) begin
          state_s = ARMED;
          kick_s  = '0;
          boot_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED, SUSPEND: begin
        // A command that moves the FSM or clears the kick counter wins over a same-cycle expiry.
        if (kick_cmd_s) begin
          state_s = ARMED;
          kick_s  = '0;
          if (Tick) boot_s = boot_inc_s;
          else      boot_s = boot_r;
        end else if (susp_cmd_s && (state_r == ARMED)) begin
          state_s = SUSPEND;
          kick_s  = '0;
          if (Tick) boot_s = boot_inc_s;
          else      boot_s = boot_r;
        end else if (dis_cmd_s) begin
          state_s = NOBOOT;
        end else if (done_cmd_s) begin
          state_s = DONE;
          fin_s   = 1'b1;
          retry_s = 4'd0;
        end else if (Tick) begin
          boot_s = boot_inc_s;
          if (state_r == ARMED) kick_s = kick_inc_s;
          else                  kick_s = kick_r;
          if (((state_r == ARMED) && (kick_inc_s == KW'(KICK_TICKS))) ||
              (boot_inc_s == BW'(BOOT_TICKS))) begin
            state_s = EXPIRED;
            retry_s = retry_inc_s;
            if (retry_inc_s < 4'(MAX_RETRY)) begin
              swap_s  = 1'b1;
              sel_s   = ~sel_r;
              wd_s    = 1'b1;
              pulse_s = PW'(RST_PULSE - 1);
            end else begin
              wd_s = 1'b0;
            end
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      NOBOOT, DONE: begin
        if (BootStart) begin
          state_s = ARMED;
          kick_s  = '0;
          boot_s  = '0;
          fin_s   = 1'b0;
        end else if (done_cmd_s && (state_r == NOBOOT)) begin
          state_s = DONE;
          fin_s   = 1'b1;
          retry_s = 4'd0;
        end else begin
          state_s = state_r;
        end
      end
      EXPIRED: begin
        if (retry_r >= 4'(MAX_RETRY)) begin
          state_s = LOCKOUT;
        end else if (pulse_r == '0) begin
          state_s = IDLE;
          wd_s    = 1'b0;
        end else begin
          pulse_s = pulse_r - PW'(1);
        end
      end
      LOCKOUT: state_s = LOCKOUT;
      default: state_s = IDLE;
    endcase
    off_s = (state_s == LOCKOUT);
    dpx_s = {((state_s == ARMED) || (state_s == SUSPEND)) && (boot_s != '0),
             (state_s == ARMED) && (kick_s != '0)};
  end

  // State and output registers.
  always_ff @(posedge LpcClock or negedge MainReset) begin
    if (!MainReset) begin
      state_r <= IDLE;
      kick_r  <= '0;
      boot_r  <= '0;
      pulse_r <= '0;
      retry_r <= 4'd0;
      sel_r   <= 1'b0;
      swap_r  <= 1'b0;
      wd_r    <= 1'b0;
      fin_r   <= 1'b0;
      off_r   <= 1'b0;
      dpx_r   <= 2'b00;
    end else begin
      state_r <= state_s;
      kick_r  <= kick_s;
      boot_r  <= boot_s;
      pulse_r <= pulse_s;
      retry_r <= retry_s;
      sel_r   <= sel_s;
      swap_r  <= swap_s;
      wd_r    <= wd_s;
      fin_r   <= fin_s;
      off_r   <= off_s;
      dpx_r   <= dpx_s;
    end
  end

  assign WdState      = state_r;
  assign RetryCnt     = retry_r;
  assign BiosSel      = sel_r;
  assign ForceSwap    = swap_r;
  assign WdReset      = wd_r;
  assign BiosFinished = fin_r;
  assign BiosPowerOff = off_r;
  assign DPx          = dpx_r;

endmodule

// File: tb/tb_bios_watchdog_multi.sv
// Directed bench for bios_watchdog_multi with hand-computed expectations.
module tb_bios_watchdog_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boot = 1'b0, tick = 1'b0, cv = 1'b0;
  logic [7:0] cd = 8'h00;
  logic       fin, wd, swap, sel, off;
  logic [3:0] retry;
  logic [2:0] st;
  logic [1:0] dpx;
  int         n_chk = 0;
  int         n_fail = 0;

  bios_watchdog_multi dut (
    .LpcClock(clk), .MainReset(rst_n), .BootStart(boot), .Tick(tick),
    .CmdValid(cv), .CmdData(cd), .BiosFinished(fin), .WdReset(wd),
    .ForceSwap(swap), .BiosSel(sel), .BiosPowerOff(off), .RetryCnt(retry),
    .WdState(st), .DPx(dpx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(1); tick = 1'b0;
  endtask

  task automatic do_cmd(input logic [7:0] c);
    cv = 1'b1; cd = c; step(1); cv = 1'b0; cd = 8'h00;
  endtask

  task automatic do_boot();
    boot = 1'b1; step(1); boot = 1'b0;
  endtask

  initial begin
    // Reset values
    step(3);
    chk("rst_state", st, 3'd0);
    chk("rst_outs", {fin, wd, swap, sel, off, retry, dpx}, 11'd0);
    rst_n = 1'b1;
    step(1);

    // Commands ignored in IDLE
    do_cmd(8'hFF);
    chk("idle_ignore_cmd", {st, fin}, {3'd0, 1'b0});

    // Arm, 31 ticks: no expiry
    do_boot();
    chk("armed", st, 3'd1);
    chk("armed_dpx0", dpx, 2'b00);
    do_tick();
    chk("dpx_running", dpx, 2'b11);
    repeat (30) do_tick();
    chk("31_ticks_no_exp", {st, wd, retry}, {3'd1, 1'b0, 4'd0});
    do_cmd(8'h12);
    chk("unknown_cmd", {st, dpx}, {3'd1, 2'b11});
    // 32nd tick expires
    do_tick();
    chk("kick_exp_state", st, 3'd5);
    chk("kick_exp_outs", {wd, swap, sel, retry}, {1'b1, 1'b1, 1'b1, 4'd1});
    step(1);
    chk("swap_one_cycle", {swap, wd}, 2'b01);
    step(14);
    chk("wd_last_cycle", {wd, st}, {1'b1, 3'd5});
    step(1);
    chk("wd_end_idle", {wd, st}, {1'b0, 3'd0});

    // BootStart ignored during EXPIRED is covered below; CMD_DONE after one expiry
    do_boot();
    do_cmd(8'hFF);
    chk("done_state", {st, fin, retry, sel}, {3'd4, 1'b1, 4'd0, 1'b1});
    do_cmd(8'hAA);
    chk("done_ignores_cmd", {st, fin}, {3'd4, 1'b1});

    // Rearm from DONE; kick in the same cycle as the 32nd tick
    do_boot();
    chk("rearm_from_done", {st, fin, sel}, {3'd1, 1'b0, 1'b1});
    repeat (31) do_tick();
    tick = 1'b1; cv = 1'b1; cd = 8'hAA;
    step(1);
    tick = 1'b0; cv = 1'b0; cd = 8'h00;
    chk("kick_cancels_exp", {st, wd, retry, dpx}, {3'd1, 1'b0, 4'd0, 2'b10});

    // Disable freezes timers
    do_cmd(8'h29);
    chk("noboot", {st, dpx}, {3'd3, 2'b00});
    repeat (40) do_tick();
    chk("noboot_frozen", {st, wd}, {3'd3, 1'b0});

    // Kick every 20 ticks, boot expiry on tick 512
    do_boot();
    for (int t = 1; t <= 511; t++) begin
      do_tick();
      if (t % 20 == 0) do_cmd(8'hAA);
    end
    chk("511_boot_ticks", {st, wd}, {3'd1, 1'b0});
    do_tick();
    chk("boot_exp", {st, wd, swap, sel, retry}, {3'd5, 1'b1, 1'b1, 1'b0, 4'd1});
    do_boot();
    chk("exp_ignores_boot", st, 3'd5);
    step(15);
    chk("boot_exp_idle", {st, wd}, {3'd0, 1'b0});

    // Suspend: 100 ticks, no expiry, boot timer running
    do_boot();
    do_cmd(8'h55);
    chk("suspend", {st, dpx}, {3'd2, 2'b00});
    repeat (100) do_tick();
    chk("suspend_100", {st, wd, dpx}, {3'd2, 1'b0, 2'b10});
    do_cmd(8'hAA);
    chk("suspend_kick", {st, dpx}, {3'd1, 2'b10});

    // Second expiry: lockout, no swap, no WdReset
    repeat (32) do_tick();
    chk("exp2", {st, wd, swap, sel, retry}, {3'd5, 1'b0, 1'b0, 1'b0, 4'd2});
    step(1);
    chk("lockout", {st, off, wd, sel}, {3'd6, 1'b1, 1'b0, 1'b0});
    do_boot();
    do_cmd(8'hFF);
    chk("lockout_sticky", {st, off, fin, retry}, {3'd6, 1'b1, 1'b0, 4'd2});

    // MainReset during a WdReset pulse
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
    chk("rst_clears_lockout", {st, off, retry}, {3'd0, 1'b0, 4'd0});
    do_boot();
    repeat (32) do_tick();
    chk("pulse_active", {wd, sel, retry}, {1'b1, 1'b1, 4'd1});
    step(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {fin, wd, swap, sel, off, retry, st, dpx}, 14'd0);
    step(2);
    chk("held_in_rst", {wd, st}, {1'b0, 3'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
